// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a one-cycle-later ack.
// Define ARB_RR_EN for round-robin arbitration; otherwise requester A has fixed priority.
//
// state | meaning
// IDLE  | no access in flight, arbitrate and latch the winner's command
// ISSUE | one-cycle RAM enable with the latched command
// WAIT  | waiting for ram_ack, read data captured when it arrives
// DONE  | one-cycle ack pulse to the winner
module ram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    input  logic              ram_ack,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic                grant_b;
    logic                owner_q;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;

`ifdef ARB_RR_EN
    // On contention the requester that did not win last time goes next.
    assign grant_b = (a_req && b_req) ? ~owner_q : b_req;
`else
    assign grant_b = ~a_req;
`endif

    assign owner = owner_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_di    = '0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (a_req || b_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ram_en    = 1'b1;
                ram_we    = cmd_we;
                ram_addr  = cmd_addr;
                ram_di    = cmd_wdata;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (ram_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                a_ack     = ~owner_q;
                b_ack     = owner_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command is frozen at grant so requester changes mid-access are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q   <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (state == IDLE && (a_req || b_req)) begin
                owner_q <= grant_b;
                if (grant_b) begin
                    cmd_we    <= b_we;
                    cmd_addr  <= b_addr;
                    cmd_wdata <= b_wdata;
                end else begin
                    cmd_we    <= a_we;
                    cmd_addr  <= a_addr;
                    cmd_wdata <= a_wdata;
                end
            end
            if (state == WAIT && ram_ack) begin
                if (owner_q) begin
                    b_rdata <= ram_do;
                end else begin
                    a_rdata <= ram_do;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (read-first memory image and arbitration rule).
module tb_ram_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_req, a_we, a_ack, b_req, b_we, b_ack;
    logic [AW-1:0] a_addr, b_addr, ram_addr;
    logic [DW-1:0] a_wdata, a_rdata, b_wdata, b_rdata, ram_di;
    logic          ram_en, ram_we, ram_ack, busy, owner;

    bit   [DW-1:0] ram_do;
    bit            ram_ack_q;
    bit            pend;
    bit            stray_ack;
    int            dly_cnt;
    int            extra_dly;
    bit   [DW-1:0] mem     [0:255];
    bit   [DW-1:0] ref_mem [0:255];
    logic          model_owner;
    logic [DW-1:0] exp_a_rdata;
    int            errors = 0;
    int            checks = 0;

    assign ram_ack = ram_ack_q | stray_ack;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_do(ram_do), .ram_ack(ram_ack), .busy(busy), .owner(owner)
    );

    // Read-first RAM; ack arrives extra_dly cycles later than the nominal next cycle.
    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            ram_do <= mem[ram_addr];
            if (ram_we === 1'b1) mem[ram_addr] <= ram_di;
            pend      <= 1'b1;
            dly_cnt   <= extra_dly;
            ram_ack_q <= (extra_dly == 0);
        end else if (pend && ram_ack_q) begin
            pend      <= 1'b0;
            ram_ack_q <= 1'b0;
        end else if (pend) begin
            if (dly_cnt == 1) ram_ack_q <= 1'b1;
            dly_cnt <= dly_cnt - 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic pick_winner(input logic ar, input logic br, input logic last);
`ifdef ARB_RR_EN
        if (ar && br) return ~last;
        return br;
`else
        return !ar;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        stray_ack = 1'b0; extra_dly = 0;
        tick(); tick();
        rst_n = 1'b1;
        model_owner = 1'b1;
        exp_a_rdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({ram_en, ram_we, a_ack, b_ack, busy, owner} !== 6'b000001) begin errors++;
            $display("FAIL reset_ctrl got=%b exp=000001", {ram_en, ram_we, a_ack, b_ack, busy, owner}); end
        checks++; if ({ram_addr, ram_di} !== '0) begin errors++;
            $display("FAIL reset_ram_bus got addr=%0h di=%0h exp=0", ram_addr, ram_di); end
        checks++; if ({a_rdata, b_rdata} !== '0) begin errors++;
            $display("FAIL reset_rdata got a=%0h b=%0h exp=0", a_rdata, b_rdata); end
    endtask

    task automatic test_single_write();
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
        tick();
        checks++; if ({ram_en, ram_we, busy, owner} !== 4'b1110) begin errors++;
            $display("FAIL wr_issue_ctrl got=%b exp=1110", {ram_en, ram_we, busy, owner}); end
        checks++; if (ram_addr !== 8'h10 || ram_di !== 32'hDEADBEEF) begin errors++;
            $display("FAIL wr_issue_bus got addr=%0h di=%0h exp addr=10 di=deadbeef", ram_addr, ram_di); end
        tick();
        checks++; if ({ram_en, ram_we, a_ack, b_ack, ram_addr, ram_di} !== '0) begin errors++;
            $display("FAIL wr_wait_idle_bus got en=%b we=%b addr=%0h di=%0h", ram_en, ram_we, ram_addr, ram_di); end
        tick();
        checks++; if ({a_ack, b_ack} !== 2'b10) begin errors++;
            $display("FAIL wr_ack got a/b=%b exp=10", {a_ack, b_ack}); end
        exp_a_rdata = ref_mem[8'h10];
        ref_mem[8'h10] = 32'hDEADBEEF;
        model_owner = 1'b0;
        a_req = 1'b0; a_we = 1'b0;
        tick();
        checks++; if ({a_ack, b_ack, busy} !== 3'b000) begin errors++;
            $display("FAIL wr_after_ack got=%b exp=000", {a_ack, b_ack, busy}); end
    endtask

    task automatic test_b_read();
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10;
        tick();
        checks++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 8'h10}) begin errors++;
            $display("FAIL rd_issue got en=%b we=%b addr=%0h exp 1 0 10", ram_en, ram_we, ram_addr); end
        tick(); tick();
        checks++; if ({a_ack, b_ack, owner} !== 3'b011) begin errors++;
            $display("FAIL rd_ack got a/b/owner=%b exp=011", {a_ack, b_ack, owner}); end
        checks++; if (b_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL rd_data got=%0h exp=deadbeef", b_rdata); end
        model_owner = 1'b1;
        b_req = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        checks++; if ({busy, a_ack, b_ack, ram_en} !== 4'b0000 || a_rdata !== exp_a_rdata) begin errors++;
            $display("FAIL stray_ack got busy/acks/en=%b a_rdata=%0h exp 0000 %0h",
                     {busy, a_ack, b_ack, ram_en}, a_rdata, exp_a_rdata); end
        tick();
        checks++; if ({busy, a_ack, b_ack} !== 3'b000) begin errors++;
            $display("FAIL stray_ack_next got=%b exp=000", {busy, a_ack, b_ack}); end
    endtask

    task automatic test_delayed_ack();
        extra_dly = 5;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({busy, a_ack, b_ack, ram_en} !== 4'b1000) begin errors++;
                $display("FAIL dly_wait[%0d] got busy/acks/en=%b exp=1000", i, {busy, a_ack, b_ack, ram_en}); end
        end
        tick();
        checks++; if ({busy, a_ack} !== 2'b10) begin errors++;
            $display("FAIL dly_ramack_cycle got busy/a_ack=%b exp=10", {busy, a_ack}); end
        tick();
        checks++; if (a_ack !== 1'b1 || a_rdata !== ref_mem[8'h10]) begin errors++;
            $display("FAIL dly_ack got ack=%b rdata=%0h exp 1 %0h", a_ack, a_rdata, ref_mem[8'h10]); end
        model_owner = 1'b0;
        a_req = 1'b0;
        tick();
        extra_dly = 0;
    endtask

    task automatic test_drop_in_issue();
        int acks = 0;
        int ack_at = -1;
        logic [DW-1:0] wd;
        wd = $urandom;
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h44; a_wdata = wd;
        tick();
        checks++; if (ram_addr !== 8'h44 || ram_di !== wd || ram_we !== 1'b1) begin errors++;
            $display("FAIL drop_issue got addr=%0h di=%0h we=%b exp 44 %0h 1", ram_addr, ram_di, ram_we, wd); end
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h55; a_wdata = ~wd;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (a_ack === 1'b1) begin acks++; ack_at = i; end
        end
        checks++; if (acks !== 1 || ack_at !== 2) begin errors++;
            $display("FAIL drop_ack got pulses=%0d at=%0d exp 1 at 2", acks, ack_at); end
        ref_mem[8'h44] = wd;
        model_owner = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int acks = 0;
        extra_dly = 3;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h33;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++; if ({ram_en, ram_we, a_ack, b_ack, busy, owner} !== 6'b000001) begin errors++;
            $display("FAIL rstw_ctrl got=%b exp=000001", {ram_en, ram_we, a_ack, b_ack, busy, owner}); end
        checks++; if ({ram_addr, ram_di, a_rdata, b_rdata} !== '0) begin errors++;
            $display("FAIL rstw_data got addr=%0h di=%0h a=%0h b=%0h exp 0", ram_addr, ram_di, a_rdata, b_rdata); end
        rst_n = 1'b1; a_req = 1'b0;
        model_owner = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_ack === 1'b1 || b_ack === 1'b1 || ram_en === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin errors++;
            $display("FAIL rstw_no_ack got activity=%0d exp=0", acks); end
        extra_dly = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        tick();
        checks++; if (ram_en !== 1'b1 || ram_addr !== 8'h10) begin errors++;
            $display("FAIL rstw_reissue got en=%b addr=%0h exp 1 10", ram_en, ram_addr); end
        tick(); tick();
        checks++; if (a_ack !== 1'b1 || a_rdata !== ref_mem[8'h10]) begin errors++;
            $display("FAIL rstw_ack got ack=%b rdata=%0h exp 1 %0h", a_ack, a_rdata, ref_mem[8'h10]); end
        model_owner = 1'b0;
        a_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int b_grants = 0;
        int exp_b_grants = 0;
        logic w;
        int n;
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'($urandom_range(15, 0));
        b_req = 1'b1; b_we = 1'b0; b_addr = AW'($urandom_range(15, 0));
        for (int g = 0; g < 4; g++) begin
            w = pick_winner(1'b1, 1'b1, model_owner);
            if (w) exp_b_grants++;
            n = 0;
            do begin tick(); n++; end while (a_ack !== 1'b1 && b_ack !== 1'b1 && n < 10);
            checks++; if ({a_ack, b_ack} !== {~w, w}) begin errors++;
                $display("FAIL b2b_grant[%0d] got a/b=%b exp=%b", g, {a_ack, b_ack}, {~w, w}); end
            checks++; if ((w ? b_rdata : a_rdata) !== ref_mem[w ? b_addr : a_addr]) begin errors++;
                $display("FAIL b2b_rdata[%0d] got=%0h exp=%0h", g, w ? b_rdata : a_rdata, ref_mem[w ? b_addr : a_addr]); end
            if (b_ack === 1'b1) b_grants++;
            model_owner = w;
            if (w) b_addr = AW'($urandom_range(15, 0));
            else   a_addr = AW'($urandom_range(15, 0));
        end
        checks++; if (b_grants !== exp_b_grants) begin errors++;
            $display("FAIL b2b_b_count got=%0d exp=%0d", b_grants, exp_b_grants); end
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic a_pend = 1'b0, b_pend = 1'b0;
        logic w, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, old;
        int n;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if (!a_pend && $urandom_range(1, 0) == 1) begin
                a_pend = 1'b1; a_we = 1'($urandom_range(1, 0));
                a_addr = AW'($urandom_range(15, 0)); a_wdata = $urandom;
            end
            if (!b_pend && $urandom_range(1, 0) == 1) begin
                b_pend = 1'b1; b_we = 1'($urandom_range(1, 0));
                b_addr = AW'($urandom_range(15, 0)); b_wdata = $urandom;
            end
            if (!a_pend && !b_pend) begin
                if ($urandom_range(1, 0) == 1) begin
                    a_pend = 1'b1; a_we = 1'($urandom_range(1, 0));
                    a_addr = AW'($urandom_range(15, 0)); a_wdata = $urandom;
                end else begin
                    b_pend = 1'b1; b_we = 1'($urandom_range(1, 0));
                    b_addr = AW'($urandom_range(15, 0)); b_wdata = $urandom;
                end
            end
            a_req = a_pend; b_req = b_pend;
            extra_dly = $urandom_range(3, 0);
            w      = pick_winner(a_pend, b_pend, model_owner);
            e_we   = w ? b_we : a_we;
            e_addr = w ? b_addr : a_addr;
            e_wd   = w ? b_wdata : a_wdata;
            old    = ref_mem[e_addr];
            if (e_we) ref_mem[e_addr] = e_wd;
            tick();
            checks++; if ({ram_en, ram_we, ram_addr, ram_di, owner} !== {1'b1, e_we, e_addr, e_wd, w}) begin errors++;
                $display("FAIL rnd_issue[%0d] got en=%b we=%b addr=%0h di=%0h own=%b exp 1 %b %0h %0h %b",
                         it, ram_en, ram_we, ram_addr, ram_di, owner, e_we, e_addr, e_wd, w); end
            n = 0;
            do begin tick(); n++; end while (a_ack !== 1'b1 && b_ack !== 1'b1 && n < 12);
            checks++; if (n !== extra_dly + 2) begin errors++;
                $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", it, n, extra_dly + 2); end
            checks++; if ({a_ack, b_ack} !== {~w, w}) begin errors++;
                $display("FAIL rnd_ack[%0d] got a/b=%b exp=%b", it, {a_ack, b_ack}, {~w, w}); end
            checks++; if ((w ? b_rdata : a_rdata) !== old) begin errors++;
                $display("FAIL rnd_rdata[%0d] got=%0h exp=%0h", it, w ? b_rdata : a_rdata, old); end
            model_owner = w;
            if (w) begin b_pend = 1'b0; b_req = 1'b0; end
            else   begin a_pend = 1'b0; a_req = 1'b0; end
            tick();
            checks++; if ({a_ack, b_ack, busy} !== 3'b000) begin errors++;
                $display("FAIL rnd_pulse[%0d] got a/b/busy=%b exp=000", it, {a_ack, b_ack, busy}); end
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_b_read();
        test_stray_ack();
        test_delayed_ack();
        test_drop_in_issue();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
